regfile_wb_controller: RTL and testbench
========================================

# regfile_wb_controller

Write-back controller and scoreboard for the 16-entry register file (`registerfile`).

- **Requesters:** the ALU and memory-load write-back paths compete for the single register-file write port. Each uses a valid/ready handshake.
- **Arbitration:** round-robin; the winner is registered onto `we`/`sel_r_in`/`data_in`.
- **Scoreboard:** per-register pending bits, set at decode reservation and cleared at commit. They drive a read-hazard stall for the two read selects and a WAW reservation stall.
- **Placement:** sits between the decode, execute and memory stages and the register file.

## Interface

Parameters:
- `DATA_W`, 32, write-data width.
- `SEL_W`, 5, register-select width.
- `NREGS`, 16, implemented registers; selects ≥ `NREGS` are out of range.

Ports (reset `rst`, synchronous, active-low; clock `clk`):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous active-low reset.
- `reserve_valid`  in  1  decode requests a destination reservation.
- `reserve_sel`  in  SEL_W  destination register to reserve.
- `reserve_ready`  out  1  reservation accepted this cycle.
- `alu_valid`, `alu_sel`, `alu_data`  in  1/SEL_W/DATA_W  ALU write-back request.
- `alu_ready`  out  1  ALU request granted.
- `mem_valid`, `mem_sel`, `mem_data`  in  1/SEL_W/DATA_W  load write-back request.
- `mem_ready`  out  1  load request granted.
- `rf_we`, `rf_sel`, `rf_data`  out  1/SEL_W/DATA_W  registered drive to the register-file write port.
- `chk_sel_a`, `chk_sel_b`  in  SEL_W  read selects presented to the register file.
- `hazard`  out  1  read of a pending register; the decode stage must stall.
- `wb_unreserved_err`  out  1  sticky flag: a committed write hit a non-pending in-range register.

## Operation

- **Handshake:** a transfer occurs when `x_valid & x_ready`. Requesters hold valid/sel/data stable until ready; ready depends combinationally on both valids.
- **Arbitration:**
  - A single valid requester is granted.
  - When both are valid, the requester not granted last wins.
  - The last-grant pointer updates only on a transfer. After reset it points to MEM, so ALU wins the first tie.
- **Commit:** on a transfer in cycle N, `rf_we=1` with the granted sel/data in cycle N+1. `rf_we=0` in every cycle without a transfer.
- **Scoreboard `pending[NREGS-1:0]`:**
  - Set on a reservation handshake.
  - Cleared at the edge ending a cycle where `rf_we=1` and `rf_sel<NREGS`.
  - If set and clear target the same register on the same edge, set wins.
- **Reservation:** `reserve_ready = ~pending[reserve_sel] | (rf_we & rf_sel==reserve_sel)`. It is 1 for out-of-range selects, which never set a bit.
- **Hazard:** `hazard = hz(chk_sel_a) | hz(chk_sel_b)`, where `hz(s) = pending[s] & ~(rf_we & rf_sel==s)`.
  - The exception exists because the register file writes before reading on the same edge.
  - Out-of-range selects give 0.
- **Unreserved write:** a commit to an in-range register whose pending bit is 0 still writes and sets `wb_unreserved_err`. The flag clears only on reset.
- **Out-of-range write:** still handshakes and drives `rf_we`. The register file ignores it and no scoreboard bit is touched.

## Timing

- **Reset values** (`rst=0` at an edge):
  - `rf_we=0`, `rf_sel=0`, `rf_data=0`.
  - pending all 0, `wb_unreserved_err=0`, pointer=MEM.
  - While `rst=0`: `alu_ready=mem_ready=reserve_ready=0`, `hazard=0`.
- **Reset mid-operation:** an in-flight commit is discarded (`rf_we=0` next cycle). The register file resets on the same edge.
- **Latency:** grant to `rf_we` is 1 cycle. Grant to register-file contents is 2 edges. A read issued in the `rf_we` cycle sees the new data.
- **Throughput:** one commit per cycle. Under sustained contention grants alternate ALU/MEM every cycle.
- **Combinational paths:** ready and hazard only; no combinational path from `x_data` to `rf_data`.

## Structure

- **Package `regfile_pkg`:**
  - `NREGS`, `DATA_W`, `SEL_W`.
  - Requester enum `req_id_t` {`REQ_ALU=0`, `REQ_MEM=1`}.
  - Scoreboard type `pending_t` (`logic [NREGS-1:0]`).
- **Sub-module `rr_arb2`:** two-input round-robin arbiter with pointer state, grant vector, and update on `accept`.
- **Top level:** scoreboard, commit register, hazard logic and error flag.

## Test plan

- **Reset:** hold `rst=0` for 2 cycles with all valids high → all readies 0, `rf_we=0`, `hazard=0`; after release, pending=0 and err=0.
- **Reserve, write, commit:**
  - Stimulus: reserve sel 3 (ready=1); set `chk_sel_a=3`; then `alu_valid` with sel 3 and data `0xDEADBEEF`.
  - Response: `alu_ready=1` the same cycle; `hazard=1` until the commit cycle; next cycle `rf_we=1`, `rf_sel=3`, `rf_data=0xDEADBEEF`, with `hazard=0` that cycle; `pending[3]=0` afterwards.
- **Contention:** both valid from reset (ALU sel 1 `0x11`, MEM sel 2 `0x22`, both reserved) → ALU granted in cycle 0 and MEM in cycle 1. A continuous 6-cycle overlap alternates A,M,A,M,A,M.
- **WAW:** reserve sel 5, then reserve sel 5 again → second `reserve_ready=0` until the `rf_we` cycle for sel 5, where it becomes 1. `pending[5]` stays 1 after that edge.
- **Unreserved and out-of-range writes:**
  - MEM write to sel 7, unreserved → write performed and `wb_unreserved_err=1` sticky.
  - ALU write to sel 20 → `rf_we=1`, no pending change, err unchanged.
- **Reset mid-commit:** drop `rst` in the cycle after an ALU grant → next cycle `rf_we=0`, pending all 0, pointer=MEM (verify with a tie: ALU wins).

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, requester ids and scoreboard type for the register-file write-back path.
package regfile_pkg;
    localparam int NREGS  = 16;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 5;
    typedef enum logic {REQ_ALU = 1'b0, REQ_MEM = 1'b1} req_id_t;
    typedef logic [NREGS-1:0] pending_t;
endpackage

// File: rtl/regfile_wb_controller_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; the pointer remembers the last accepted winner.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);
    import regfile_pkg::*;
    req_id_t last_q, last_d;
    always_comb begin
        gnt_o  = {req_i[1] & (~req_i[0] | last_q == REQ_ALU),
                  req_i[0] & (~req_i[1] | last_q == REQ_MEM)};
        last_d = accept_i ? (gnt_o[1] ? REQ_MEM : REQ_ALU) : last_q;
    end
    always_ff @(posedge clk)
        last_q <= !rst ? REQ_MEM : last_d;
endmodule

// File: rtl/regfile_wb_controller.sv
// regfile_wb_controller: arbitrates ALU/load write-backs onto the register-file port and tracks pending registers.
module regfile_wb_controller #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int SEL_W  = regfile_pkg::SEL_W,
    parameter int NREGS  = regfile_pkg::NREGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reserve_valid,
    input  logic [SEL_W-1:0]  reserve_sel,
    output logic              reserve_ready,
    input  logic              alu_valid,
    input  logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [SEL_W-1:0]  mem_sel,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic              rf_we,
    output logic [SEL_W-1:0]  rf_sel,
    output logic [DATA_W-1:0] rf_data,
    input  logic [SEL_W-1:0]  chk_sel_a,
    input  logic [SEL_W-1:0]  chk_sel_b,
    output logic              hazard,
    output logic              wb_unreserved_err
);
    import regfile_pkg::*;
    localparam int IW = $clog2(NREGS);

    logic [1:0]        gnt;
    logic              xfer;
    logic [NREGS-1:0]  pend_q, pend_d, set_m, clr_m;
    logic              rf_we_q, err_q, err_d;
    logic [SEL_W-1:0]  rf_sel_q;
    logic [DATA_W-1:0] rf_data_q;

    function automatic logic in_rng(input logic [SEL_W-1:0] s);
        return int'(s) < NREGS;
    endfunction

    // The register file writes before it reads, so a register committing this cycle is not a hazard.
    function automatic logic hz(input logic [SEL_W-1:0] s);
        return in_rng(s) && pend_q[s[IW-1:0]] && !(rf_we_q && rf_sel_q == s);
    endfunction

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    ({mem_valid, alu_valid}),
        .accept_i (xfer),
        .gnt_o    (gnt)
    );

    always_comb begin
        alu_ready     = rst & gnt[REQ_ALU];
        mem_ready     = rst & gnt[REQ_MEM];
        xfer          = alu_ready | mem_ready;
        reserve_ready = rst & (!in_rng(reserve_sel) || !pend_q[reserve_sel[IW-1:0]]
                               || (rf_we_q && rf_sel_q == reserve_sel));
        hazard        = rst & (hz(chk_sel_a) | hz(chk_sel_b));
        clr_m         = (rf_we_q && in_rng(rf_sel_q)) ? NREGS'(1) << rf_sel_q[IW-1:0] : '0;
        set_m         = (reserve_valid && reserve_ready && in_rng(reserve_sel))
                        ? NREGS'(1) << reserve_sel[IW-1:0] : '0;
        pend_d        = (pend_q & ~clr_m) | set_m;
        err_d         = err_q | (|(clr_m & ~pend_q));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_we_q   <= 1'b0;
            rf_sel_q  <= '0;
            rf_data_q <= '0;
            pend_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            rf_we_q <= xfer;
            if (xfer) begin
                rf_sel_q  <= alu_ready ? alu_sel : mem_sel;
                rf_data_q <= alu_ready ? alu_data : mem_data;
            end
            pend_q <= pend_d;
            err_q  <= err_d;
        end
    end

    assign rf_we             = rf_we_q;
    assign rf_sel            = rf_sel_q;
    assign rf_data           = rf_data_q;
    assign wb_unreserved_err = err_q;
endmodule

// File: tb/tb_regfile_wb_controller.sv
// tb_regfile_wb_controller: directed vectors with hand-computed expectations for the write-back controller.
module tb_regfile_wb_controller;
    logic        clk = 1'b0;
    logic        rst;
    logic        reserve_valid, reserve_ready;
    logic [4:0]  reserve_sel;
    logic        alu_valid, alu_ready, mem_valid, mem_ready;
    logic [4:0]  alu_sel, mem_sel;
    logic [31:0] alu_data, mem_data;
    logic        rf_we;
    logic [4:0]  rf_sel;
    logic [31:0] rf_data;
    logic [4:0]  chk_sel_a, chk_sel_b;
    logic        hazard, wb_unreserved_err;
    int          vecs = 0, errs = 0;

    always #5 clk = ~clk;

    regfile_wb_controller dut (
        .clk(clk), .rst(rst),
        .reserve_valid(reserve_valid), .reserve_sel(reserve_sel), .reserve_ready(reserve_ready),
        .alu_valid(alu_valid), .alu_sel(alu_sel), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_sel(mem_sel), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_we(rf_we), .rf_sel(rf_sel), .rf_data(rf_data),
        .chk_sel_a(chk_sel_a), .chk_sel_b(chk_sel_b),
        .hazard(hazard), .wb_unreserved_err(wb_unreserved_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        rst = 1'b0;
        reserve_valid = 1'b1; reserve_sel = 5'd3;
        alu_valid = 1'b1; alu_sel = 5'd1; alu_data = 32'h1;
        mem_valid = 1'b1; mem_sel = 5'd2; mem_data = 32'h2;
        chk_sel_a = 5'd3; chk_sel_b = 5'd5;
        // Reset held two cycles with every requester active
        for (int i = 0; i < 2; i++) begin
            tick;
            chk("rst_alu_ready", alu_ready, 0);
            chk("rst_mem_ready", mem_ready, 0);
            chk("rst_res_ready", reserve_ready, 0);
            chk("rst_rf_we", rf_we, 0);
            chk("rst_hazard", hazard, 0);
        end
        chk("rst_rf_sel", rf_sel, 0);
        chk("rst_rf_data", rf_data, 0);
        rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0; reserve_valid = 1'b0;
        settle;
        chk("post_rst_hazard", hazard, 0);
        chk("post_rst_err", wb_unreserved_err, 0);

        // Reserve, write, commit on sel 3
        reserve_valid = 1'b1; reserve_sel = 5'd3; settle;
        chk("res3_ready", reserve_ready, 1);
        tick;
        reserve_valid = 1'b0; settle;
        chk("res3_hazard", hazard, 1);
        alu_valid = 1'b1; alu_sel = 5'd3; alu_data = 32'hDEADBEEF; settle;
        chk("wb3_alu_ready", alu_ready, 1);
        chk("wb3_hazard_grant", hazard, 1);
        tick;
        alu_valid = 1'b0; settle;
        chk("wb3_rf_we", rf_we, 1);
        chk("wb3_rf_sel", rf_sel, 3);
        chk("wb3_rf_data", rf_data, 32'hDEADBEEF);
        chk("wb3_hazard_commit", hazard, 0);
        tick;
        chk("wb3_rf_we_off", rf_we, 0);
        chk("wb3_pending_clr", hazard, 0);
        chk("wb3_err", wb_unreserved_err, 0);

        // Contention from a fresh reset
        rst = 1'b0; tick; rst = 1'b1;
        reserve_valid = 1'b1; reserve_sel = 5'd1; tick;
        reserve_sel = 5'd2; tick;
        reserve_valid = 1'b0;
        alu_valid = 1'b1; alu_sel = 5'd1; alu_data = 32'h11;
        mem_valid = 1'b1; mem_sel = 5'd2; mem_data = 32'h22; settle;
        chk("tie0_alu", alu_ready, 1);
        chk("tie0_mem", mem_ready, 0);
        tick;
        alu_valid = 1'b0; settle;
        chk("tie1_mem", mem_ready, 1);
        chk("tie0_rf_sel", rf_sel, 1);
        chk("tie0_rf_data", rf_data, 32'h11);
        tick;
        chk("tie1_rf_sel", rf_sel, 2);
        chk("tie1_rf_data", rf_data, 32'h22);
        // Six overlapping cycles on out-of-range selects must alternate A,M,A,M,A,M
        alu_valid = 1'b1; alu_sel = 5'd20;
        mem_sel = 5'd21;
        for (int i = 0; i < 6; i++) begin
            alu_data = 32'(i); mem_data = 32'h100 + 32'(i); settle;
            chk("alt_alu_ready", alu_ready, (i % 2 == 0) ? 1 : 0);
            chk("alt_mem_ready", mem_ready, (i % 2 == 0) ? 0 : 1);
            tick;
            chk("alt_rf_sel", rf_sel, (i % 2 == 0) ? 20 : 21);
            chk("alt_rf_data", rf_data, (i % 2 == 0) ? 32'(i) : 32'h100 + 32'(i));
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick;
        chk("alt_idle_we", rf_we, 0);
        chk("alt_err", wb_unreserved_err, 0);

        // WAW reservation stall on sel 5
        reserve_valid = 1'b1; reserve_sel = 5'd5; settle;
        chk("waw_first", reserve_ready, 1);
        tick;
        chk("waw_second", reserve_ready, 0);
        tick;
        chk("waw_hold", reserve_ready, 0);
        alu_valid = 1'b1; alu_sel = 5'd5; alu_data = 32'h55; settle;
        chk("waw_alu_ready", alu_ready, 1);
        chk("waw_pre_commit", reserve_ready, 0);
        tick;
        alu_valid = 1'b0; chk_sel_a = 5'd5; settle;
        chk("waw_commit_ready", reserve_ready, 1);
        chk("waw_commit_hazard", hazard, 0);
        tick;
        reserve_valid = 1'b0; settle;
        chk("waw_set_wins", hazard, 1);
        alu_valid = 1'b1; tick;
        alu_valid = 1'b0; tick;
        chk("waw_cleared", hazard, 0);

        // Unreserved load write to sel 7
        mem_valid = 1'b1; mem_sel = 5'd7; mem_data = 32'h77; settle;
        chk("unres_mem_ready", mem_ready, 1);
        tick;
        mem_valid = 1'b0; settle;
        chk("unres_rf_we", rf_we, 1);
        chk("unres_rf_sel", rf_sel, 7);
        chk("unres_rf_data", rf_data, 32'h77);
        chk("unres_err_before", wb_unreserved_err, 0);
        tick;
        chk("unres_err_set", wb_unreserved_err, 1);
        tick;
        chk("unres_err_sticky", wb_unreserved_err, 1);

        // Out-of-range ALU write and reservation on sel 20
        alu_valid = 1'b1; alu_sel = 5'd20; alu_data = 32'hAB;
        reserve_valid = 1'b1; reserve_sel = 5'd20; chk_sel_a = 5'd20; chk_sel_b = 5'd4; settle;
        chk("oor_res_ready", reserve_ready, 1);
        chk("oor_hazard", hazard, 0);
        tick;
        alu_valid = 1'b0; reserve_valid = 1'b0; settle;
        chk("oor_rf_we", rf_we, 1);
        chk("oor_rf_sel", rf_sel, 20);
        tick;
        chk("oor_no_pending", hazard, 0);
        chk("oor_err", wb_unreserved_err, 1);

        // Reset in the cycle after an ALU grant
        reserve_valid = 1'b1; reserve_sel = 5'd10; tick;
        reserve_sel = 5'd9; tick;
        reserve_valid = 1'b0;
        alu_valid = 1'b1; alu_sel = 5'd9; alu_data = 32'h99; tick;
        chk_sel_a = 5'd9; chk_sel_b = 5'd10;
        rst = 1'b0; mem_valid = 1'b1; mem_sel = 5'd2; mem_data = 32'h22; settle;
        chk("mid_rst_rf_we", rf_we, 1);
        chk("mid_rst_alu_ready", alu_ready, 0);
        chk("mid_rst_hazard", hazard, 0);
        tick;
        rst = 1'b1; settle;
        chk("mid_rst_discard", rf_we, 0);
        chk("mid_rst_pending", hazard, 0);
        chk("mid_rst_err", wb_unreserved_err, 0);
        chk("mid_rst_tie_alu", alu_ready, 1);
        chk("mid_rst_tie_mem", mem_ready, 0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
